// File: rtl/limbus_timer_sched.sv
// Round-robin owner of the single limbus interval timer: one-shot per grant, wait irq, clear, pulse done.
// Optional LIMBUS_TSCHED_CANCEL_EN: owner dropping req in WAIT stops the timer and skips done.
module limbus_timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   period,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [2:0]              av_address,
  output logic                    av_chipselect,
  output logic                    av_write_n,
  output logic [15:0]             av_writedata,
  input  logic                    irq_in
);

  localparam logic [2:0]  A_STATUS  = 3'd0;
  localparam logic [2:0]  A_CONTROL = 3'd1;
  localparam logic [2:0]  A_PERL    = 3'd2;
  localparam logic [2:0]  A_PERH    = 3'd3;
  localparam logic [15:0] CTL_START = 16'h0005;
  localparam logic [15:0] CTL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_WR_PL, S_WR_PH, S_WR_CTL, S_WAIT, S_STOP, S_CLR, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt, gid_nxt, pick, kk;
  logic                pick_vld;
  logic [31:0]         per_q, per_nxt, pick_per;
  logic                cancel_q, cancel_nxt;
  logic [NUM_REQ-1:0]  done_nxt;
  logic                busy_nxt, cs_nxt, wn_nxt;
  logic [2:0]          addr_nxt;
  logic [15:0]         data_nxt;

  // Walk downward so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    kk       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      kk = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[kk]) begin
        pick     = kk;
        pick_vld = 1'b1;
      end
    end
    pick_per = period[32*pick +: 32];
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gid_nxt    = grant_id;
    per_nxt    = per_q;
    cancel_nxt = cancel_q;
    case (state)
      S_IDLE:   if (|req) state_nxt = S_ARB;
      S_ARB: begin
        if (pick_vld) begin
          gid_nxt    = pick;
          per_nxt    = pick_per;
          ptr_nxt    = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          cancel_nxt = 1'b0;
          state_nxt  = (pick_per == '0) ? S_DONE : S_WR_PL;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_WR_PL:  state_nxt = S_WR_PH;
      S_WR_PH:  state_nxt = S_WR_CTL;
      S_WR_CTL: state_nxt = S_WAIT;
      S_WAIT: begin
        if (irq_in) begin
          state_nxt = S_CLR;
        end
`ifdef LIMBUS_TSCHED_CANCEL_EN
        else if (!req[grant_id]) begin
          state_nxt  = S_STOP;
          cancel_nxt = 1'b1;
        end
`endif
      end
      S_STOP:   state_nxt = S_CLR;
      S_CLR:    state_nxt = cancel_q ? S_IDLE : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus and status outputs are decoded from the next state so they register in the state's own cycle.
  always_comb begin
    cs_nxt   = 1'b0;
    wn_nxt   = 1'b1;
    addr_nxt = av_address;
    data_nxt = av_writedata;
    done_nxt = '0;
    busy_nxt = (state_nxt != S_IDLE);
    case (state_nxt)
      S_WR_PL: begin
        cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_PERL;    data_nxt = per_nxt[15:0];
      end
      S_WR_PH: begin
        cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_PERH;    data_nxt = per_nxt[31:16];
      end
      S_WR_CTL: begin
        cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_CONTROL; data_nxt = CTL_START;
      end
      S_STOP: begin
        cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_CONTROL; data_nxt = CTL_STOP;
      end
      S_CLR: begin
        cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_STATUS;  data_nxt = 16'h0000;
      end
      S_DONE:  done_nxt[gid_nxt] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      grant_id      <= '0;
      per_q         <= '0;
      cancel_q      <= 1'b0;
      done          <= '0;
      busy          <= 1'b0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_address    <= '0;
      av_writedata  <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      grant_id      <= gid_nxt;
      per_q         <= per_nxt;
      cancel_q      <= cancel_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
      av_chipselect <= cs_nxt;
      av_write_n    <= wn_nxt;
      av_address    <= addr_nxt;
      av_writedata  <= data_nxt;
    end
  end

endmodule
